// File: rtl/zeroriscy_instr_aligner_if.sv
// Fetch-side and decode-side handshake bundle for the instruction aligner.
// Signal names are seen from the aligner: _i enters it, _o leaves it.
interface zeroriscy_instr_aligner_if;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_addr_o;
    logic        branch_i;
    logic [31:0] branch_addr_i;

    modport slave (
        input  fetch_valid_i, fetch_rdata_i, instr_ready_i, branch_i, branch_addr_i,
        output fetch_ready_o, instr_valid_o, instr_rdata_o, instr_addr_o
    );

    modport master (
        output fetch_valid_i, fetch_rdata_i, instr_ready_i, branch_i, branch_addr_i,
        input  fetch_ready_o, instr_valid_o, instr_rdata_o, instr_addr_o
    );
endinterface

// File: rtl/zeroriscy_instr_aligner.sv
// Splits word-aligned fetch words into 16/32-bit instructions, stitching
// 32-bit instructions that straddle two fetch words.
module zeroriscy_instr_aligner #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic                       clk,
    input  logic                       rst_n,
    zeroriscy_instr_aligner_if.slave   bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned HLEN = 16;

    typedef enum logic [1:0] {
        S_ALIGNED = 2'd0,
        S_HOLD    = 2'd1,
        S_SKIP    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [HLEN-1:0]   hold_q,  hold_d;
    logic [XLEN-1:0]   pc_q,    pc_d;
    logic [XLEN-1:0]   w;
    logic              fire;

    assign w = bus.fetch_rdata_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_ALIGNED;
            hold_q  <= '0;
            pc_q    <= BOOT_ADDR;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            pc_q    <= pc_d;
        end
    end

    // Next state and combinational handshake; fire never feeds instr_valid_o.
    always_comb begin
        state_d           = state_q;
        hold_d            = hold_q;
        pc_d              = pc_q;
        fire              = 1'b0;
        bus.instr_valid_o = 1'b0;
        bus.fetch_ready_o = 1'b0;
        bus.instr_rdata_o = w;
        bus.instr_addr_o  = pc_q;

        unique case (state_q)
            S_ALIGNED: begin
                bus.instr_valid_o = bus.fetch_valid_i;
                bus.fetch_ready_o = bus.instr_ready_i;
                fire              = bus.fetch_valid_i & bus.instr_ready_i;
                if (w[1:0] == 2'b11) begin
                    bus.instr_rdata_o = w;
                    if (fire) pc_d = pc_q + XLEN'(4);
                end else begin
                    bus.instr_rdata_o = {16'h0000, w[15:0]};
                    if (fire) begin
                        hold_d  = w[31:16];
                        pc_d    = pc_q + XLEN'(2);
                        state_d = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (hold_q[1:0] != 2'b11) begin
                    bus.instr_valid_o = 1'b1;
                    bus.instr_rdata_o = {16'h0000, hold_q};
                    fire              = bus.instr_ready_i;
                    if (fire) begin
                        pc_d    = pc_q + XLEN'(2);
                        state_d = S_ALIGNED;
                    end
                end else begin
                    bus.instr_valid_o = bus.fetch_valid_i;
                    bus.fetch_ready_o = bus.instr_ready_i;
                    bus.instr_rdata_o = {w[15:0], hold_q};
                    fire              = bus.fetch_valid_i & bus.instr_ready_i;
                    if (fire) begin
                        hold_d = w[31:16];
                        pc_d   = pc_q + XLEN'(4);
                    end
                end
            end

            S_SKIP: begin
                // Low halfword precedes the branch target and is dropped.
                if (w[17:16] != 2'b11) begin
                    bus.instr_valid_o = bus.fetch_valid_i;
                    bus.fetch_ready_o = bus.instr_ready_i;
                    bus.instr_rdata_o = {16'h0000, w[31:16]};
                    fire              = bus.fetch_valid_i & bus.instr_ready_i;
                    if (fire) begin
                        pc_d    = pc_q + XLEN'(2);
                        state_d = S_ALIGNED;
                    end
                end else begin
                    bus.fetch_ready_o = 1'b1;
                    if (bus.fetch_valid_i) begin
                        hold_d  = w[31:16];
                        state_d = S_HOLD;
                    end
                end
            end

            default: begin
                state_d = S_ALIGNED;
            end
        endcase

        if (bus.branch_i) begin
            bus.instr_valid_o = 1'b0;
            bus.fetch_ready_o = 1'b0;
            hold_d            = '0;
            pc_d              = bus.branch_addr_i & ~XLEN'(1);
            state_d           = bus.branch_addr_i[1] ? S_SKIP : S_ALIGNED;
        end

        if (!rst_n) begin
            bus.instr_valid_o = 1'b0;
            bus.fetch_ready_o = 1'b0;
        end
    end
endmodule
